// File: rtl/gppcu_instr_feeder.sv
// Streams program RAM words to a core over a valid/ready link.
// Define GPPCU_FEEDER_HALT_OPC_EN to stop runs at a HALT_OPC word.
module gppcu_instr_feeder #(
  parameter int         DBW      = 32,
  parameter int         PAW      = 8,
  parameter int         OPC_LSB  = 0,
  parameter logic [4:0] HALT_OPC = 5'h1F
) (
  input  logic           iACLK,
  input  logic           inRST,
  input  logic           iPROG_WR,
  input  logic [PAW-1:0] iPROG_ADDR,
  input  logic [DBW-1:0] iPROG_WDATA,
  input  logic           iSTART,
  input  logic [PAW-1:0] iSTART_ADDR,
  input  logic [PAW:0]   iLENGTH,
  input  logic           iABORT,
  output logic [DBW-1:0] oINSTR,
  output logic           oINSTR_VALID,
  input  logic           iINSTR_READY,
  output logic           oBUSY,
  output logic           oDONE,
  output logic [PAW-1:0] oPC
);

`ifdef GPPCU_FEEDER_HALT_OPC_EN
  localparam logic HALT_EN = 1'b1;
`else
  localparam logic HALT_EN = 1'b0;
`endif

  localparam logic [PAW-1:0] ONE   = 1;
  localparam logic [PAW:0]   C_ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    PREFETCH,
    ISSUE
  } state_t;

  state_t         state;
  logic [DBW-1:0] mem [2**PAW];
  logic [DBW-1:0] rdata;
  logic [PAW-1:0] raddr;
  logic [PAW-1:0] rd_addr;
  logic [PAW:0]   cnt;
  logic           rd_en;
  logic           xfer;
  logic           halt;

  assign xfer  = oINSTR_VALID & iINSTR_READY;
  assign halt  = HALT_EN & (rdata[OPC_LSB +: 5] == HALT_OPC);
  assign oBUSY = (state != IDLE);

  // rdata always holds the word at raddr, one ahead of oINSTR
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = raddr + ONE;
    unique case (state)
      IDLE: begin
        rd_en   = iSTART & ~iABORT & (iLENGTH != '0);
        rd_addr = iSTART_ADDR;
      end
      PREFETCH: rd_en = 1'b1;
      ISSUE:    rd_en = xfer;
      default:  rd_en = 1'b0;
    endcase
  end

  always_ff @(posedge iACLK) begin
    if (iPROG_WR && state == IDLE)
      mem[iPROG_ADDR] <= iPROG_WDATA;
    if (rd_en)
      rdata <= mem[rd_addr];
  end

  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      state        <= IDLE;
      oINSTR_VALID <= 1'b0;
      oDONE        <= 1'b0;
      oPC          <= '0;
      oINSTR       <= '0;
      cnt          <= '0;
      raddr        <= '0;
    end else begin
      oDONE <= 1'b0;
      unique case (state)
        IDLE: begin
          if (iSTART && !iABORT) begin
            if (iLENGTH == '0) begin
              oDONE <= 1'b1;
            end else begin
              raddr <= iSTART_ADDR;
              cnt   <= iLENGTH;
              state <= PREFETCH;
            end
          end
        end
        PREFETCH: begin
          if (iABORT) begin
            state <= IDLE;
          end else if (halt) begin
            state <= IDLE;
            oDONE <= 1'b1;
          end else begin
            state        <= ISSUE;
            oINSTR_VALID <= 1'b1;
            oINSTR       <= rdata;
            oPC          <= raddr;
            raddr        <= raddr + ONE;
          end
        end
        ISSUE: begin
          if (iABORT) begin
            state        <= IDLE;
            oINSTR_VALID <= 1'b0;
          end else if (xfer) begin
            cnt <= cnt - C_ONE;
            if (cnt == C_ONE || halt) begin
              state        <= IDLE;
              oINSTR_VALID <= 1'b0;
              oDONE        <= 1'b1;
            end else begin
              oINSTR <= rdata;
              oPC    <= raddr;
              raddr  <= raddr + ONE;
            end
          end
        end
        default: begin
          state        <= IDLE;
          oINSTR_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule
